// File: rtl/usb_output.sv
// FT245 transmit path: byte FIFO from the design drained to the FTDI chip
// using the TXE#/WR write handshake.
module usb_output #(
    parameter int ADDR_BITS      = 4,
    parameter int SETUP_CYCLES   = 1,
    parameter int WR_CYCLES      = 2,
    parameter int RECOVER_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           in_data,
    input  logic                 push,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow,
    input  logic                 txe,
    output logic                 wr,
    output logic [7:0]           usb_data_out,
    output logic                 usb_data_oe,
    output logic [2:0]           state
);

    localparam int DEPTH_N = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH = (ADDR_BITS + 1)'(DEPTH_N);
    localparam logic [ADDR_BITS:0] CNT_ONE = 1;
    localparam logic [ADDR_BITS-1:0] PTR_ONE = 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } state_t;

    state_t cur, nxt;
    logic [7:0] cyc, cyc_nxt;
    logic txe_meta, txe_s;
    logic [7:0] mem [DEPTH_N];
    logic [ADDR_BITS-1:0] wptr, rptr;
    logic push_ok, pop;

    // full is judged on the pre-edge occupancy, so a pop cannot make room
    // for a push on the same edge.
    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop     = (cur == IDLE) && !empty && !txe_s;

    // Two-flop synchronizer for TXE#, idles as "not ready".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txe_meta <= 1'b1;
            txe_s    <= 1'b1;
        end else begin
            txe_meta <= txe;
            txe_s    <= txe_meta;
        end
    end

    // FIFO storage; contents are don't-care once pointers reset.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr] <= in_data;
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wptr <= wptr + PTR_ONE;
            if (pop)
                rptr <= rptr + PTR_ONE;
            if (push && full)
                overflow <= 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Output byte register, loaded from the FIFO head when a byte starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            usb_data_out <= 8'd0;
        else if (pop)
            usb_data_out <= mem[rptr];
    end

    // FSM state and phase counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur <= IDLE;
            cyc <= 8'd0;
        end else begin
            cur <= nxt;
            cyc <= cyc_nxt;
        end
    end

    // Next-state logic walking SETUP, STROBE, HOLD and RECOVER phases.
    always_comb begin
        nxt     = cur;
        cyc_nxt = cyc + 8'd1;
        case (cur)
            IDLE: begin
                cyc_nxt = 8'd0;
                if (pop)
                    nxt = SETUP;
            end
            SETUP: begin
                if (cyc == 8'(SETUP_CYCLES - 1)) begin
                    nxt     = STROBE;
                    cyc_nxt = 8'd0;
                end
            end
            STROBE: begin
                if (cyc == 8'(WR_CYCLES - 1)) begin
                    nxt     = HOLD;
                    cyc_nxt = 8'd0;
                end
            end
            HOLD: begin
                nxt     = RECOVER;
                cyc_nxt = 8'd0;
            end
            RECOVER: begin
                if (cyc == 8'(RECOVER_CYCLES - 1)) begin
                    nxt     = IDLE;
                    cyc_nxt = 8'd0;
                end
            end
            default: begin
                nxt     = IDLE;
                cyc_nxt = 8'd0;
            end
        endcase
    end

    // Strobes decode straight from the state register so reset clears them at once.
    assign wr          = (cur == STROBE);
    assign usb_data_oe = (cur == SETUP) || (cur == STROBE) || (cur == HOLD);
    assign state       = cur;

endmodule

// File: tb/tb_usb_output.sv
// Randomized bench for usb_output against a queue-based FIFO and
// per-byte timeline model of the FT245 write handshake.
module tb_usb_output;

    localparam int DEPTH  = 16;
    localparam int S      = 1;
    localparam int W      = 2;
    localparam int R      = 3;
    localparam int PERIOD = 1 + S + W + 1 + R;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       push;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       txe;
    logic       wr;
    logic [7:0] usb_data_out;
    logic       usb_data_oe;
    logic [2:0] state;

    usb_output dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .push         (push),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .txe          (txe),
        .wr           (wr),
        .usb_data_out (usb_data_out),
        .usb_data_oe  (usb_data_oe),
        .state        (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic [7:0] rx[$];
    bit         m_meta, m_sync, m_active, m_ovf, prev_wr;
    int         m_age;
    logic [7:0] m_cur;

    task automatic model_reset();
        q.delete();
        rx.delete();
        m_meta   = 1'b1;
        m_sync   = 1'b1;
        m_active = 1'b0;
        m_age    = 0;
        m_cur    = 8'd0;
        m_ovf    = 1'b0;
        prev_wr  = 1'b0;
    endtask

    function automatic bit exp_wr();
        return m_active && m_age >= S && m_age < S + W;
    endfunction

    function automatic bit exp_oe();
        return m_active && m_age <= S + W;
    endfunction

    task automatic tick(input bit p, input logic [7:0] d, input bit t);
        bit do_pop, do_push;
        push    = p;
        in_data = d;
        txe     = t;
        do_pop  = !m_active && q.size() > 0 && !m_sync;
        do_push = p && q.size() < DEPTH;
        if (p && !do_push)
            m_ovf = 1'b1;
        if (do_pop) begin
            m_cur    = q.pop_front();
            m_active = 1'b1;
            m_age    = 0;
        end else if (m_active) begin
            m_age++;
            if (m_age == PERIOD - 1)
                m_active = 1'b0;
        end
        if (do_push)
            q.push_back(d);
        m_sync = m_meta;
        m_meta = t;
        @(posedge clk);
        @(negedge clk);
        if (prev_wr && !wr)
            rx.push_back(usb_data_out);
        prev_wr = wr;
    endtask

    task automatic do_reset();
        push    = 1'b0;
        in_data = 8'd0;
        txe     = 1'b1;
        reset   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 8;
        if (wr !== 1'b0) begin errors++; $display("FAIL rst_wr got %b exp 0", wr); end
        if (usb_data_oe !== 1'b0) begin errors++; $display("FAIL rst_oe got %b exp 0", usb_data_oe); end
        if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", empty); end
        if (full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", full); end
        if (count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", overflow); end
        if (state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
        if (usb_data_out !== 8'd0) begin errors++; $display("FAIL rst_data got %h exp 00", usb_data_out); end
        for (int i = 0; i < 5; i++)
            tick(1'b1, 8'(i + 8'h40), 1'b1);
        checks++;
        if (count !== 5'd5) begin errors++; $display("FAIL rst_pre_count got %0d exp 5", count); end
        reset = 1'b1;
        #1;
        checks += 2;
        if (empty !== 1'b1) begin errors++; $display("FAIL rst_async_empty got %b exp 1", empty); end
        if (count !== 5'd0) begin errors++; $display("FAIL rst_async_count got %0d exp 0", count); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        int nwr = 0;
        rx.delete();
        for (int i = 0; i < 3; i++)
            tick(1'b0, 8'd0, 1'b0);
        tick(1'b1, 8'hA5, 1'b0);
        checks++;
        if (count !== 5'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
        tick(1'b0, 8'd0, 1'b0);
        checks += 3;
        if (state !== 3'd1) begin errors++; $display("FAIL single_setup got %0d exp 1", state); end
        if (usb_data_oe !== 1'b1) begin errors++; $display("FAIL single_oe got %b exp 1", usb_data_oe); end
        if (usb_data_out !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", usb_data_out); end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 8'd0, 1'b0);
            if (wr === 1'b1)
                nwr++;
            checks += 2;
            if (wr !== exp_wr()) begin errors++; $display("FAIL single_wr cyc %0d got %b exp %b", i, wr, exp_wr()); end
            if (usb_data_oe !== exp_oe()) begin errors++; $display("FAIL single_oe cyc %0d got %b exp %b", i, usb_data_oe, exp_oe()); end
            if (exp_oe()) begin
                checks++;
                if (usb_data_out !== 8'hA5) begin errors++; $display("FAIL single_hold_data got %h exp a5", usb_data_out); end
            end
        end
        checks += 3;
        if (nwr != W) begin errors++; $display("FAIL single_wr_len got %0d exp %0d", nwr, W); end
        if (state !== 3'd0) begin errors++; $display("FAIL single_idle got %0d exp 0", state); end
        if (rx.size() != 1 || rx[0] !== 8'hA5) begin errors++; $display("FAIL single_rx got %0d bytes exp 1 byte a5", rx.size()); end
    endtask

    task automatic test_txe_hold();
        rx.delete();
        for (int i = 0; i < 3; i++)
            tick(1'b0, 8'd0, 1'b1);
        for (int i = 1; i <= 3; i++)
            tick(1'b1, 8'(i), 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 8'd0, 1'b1);
            checks++;
            if (wr !== 1'b0) begin errors++; $display("FAIL hold_no_wr got %b exp 0", wr); end
        end
        checks++;
        if (count !== 5'd3) begin errors++; $display("FAIL hold_count got %0d exp 3", count); end
        for (int i = 0; i < 3 * PERIOD + 6; i++) begin
            tick(1'b0, 8'd0, 1'b0);
            checks += 2;
            if (wr !== exp_wr()) begin errors++; $display("FAIL hold_wr cyc %0d got %b exp %b", i, wr, exp_wr()); end
            if (count !== 5'(q.size())) begin errors++; $display("FAIL hold_cnt cyc %0d got %0d exp %0d", i, count, q.size()); end
            if (exp_oe()) begin
                checks++;
                if (usb_data_out !== m_cur) begin errors++; $display("FAIL hold_data got %h exp %h", usb_data_out, m_cur); end
            end
        end
        checks++;
        if (rx.size() != 3) begin errors++; $display("FAIL hold_rx_size got %0d exp 3", rx.size()); end
        for (int i = 0; i < 3 && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== 8'(i + 1)) begin errors++; $display("FAIL hold_rx[%0d] got %h exp %h", i, rx[i], i + 1); end
        end
    endtask

    task automatic test_overflow();
        rx.delete();
        for (int i = 0; i < 3; i++)
            tick(1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 17; i++) begin
            tick(1'b1, 8'(i), 1'b1);
            if (i == 14) begin
                checks++;
                if (full !== 1'b0) begin errors++; $display("FAIL ovf_full15 got %b exp 0", full); end
            end
            if (i == 15) begin
                checks += 2;
                if (full !== 1'b1) begin errors++; $display("FAIL ovf_full16 got %b exp 1", full); end
                if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", overflow); end
            end
        end
        checks += 2;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", count); end
        for (int i = 0; i < 16 * PERIOD + 8; i++) begin
            tick(1'b0, 8'd0, 1'b0);
            checks += 3;
            if (count !== 5'(q.size())) begin errors++; $display("FAIL ovf_cnt cyc %0d got %0d exp %0d", i, count, q.size()); end
            if (full !== (q.size() == DEPTH)) begin errors++; $display("FAIL ovf_fullc cyc %0d got %b", i, full); end
            if (wr !== exp_wr()) begin errors++; $display("FAIL ovf_wr cyc %0d got %b exp %b", i, wr, exp_wr()); end
        end
        checks++;
        if (rx.size() != 16) begin errors++; $display("FAIL ovf_rx_size got %0d exp 16", rx.size()); end
        for (int i = 0; i < 16 && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== 8'(i)) begin errors++; $display("FAIL ovf_rx[%0d] got %h exp %h", i, rx[i], i); end
        end
    endtask

    task automatic test_reset_mid();
        int nwr = 0;
        bit seen = 1'b0;
        rx.delete();
        for (int i = 0; i < 3; i++)
            tick(1'b1, 8'(8'hC0 + i), 1'b0);
        for (int i = 0; i < 30 && !seen; i++) begin
            if (wr === 1'b1 && state === 3'd2)
                seen = 1'b1;
            else
                tick(1'b0, 8'd0, 1'b0);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL mid_strobe_timeout got wr %b exp 1", wr); end
        reset = 1'b1;
        #1;
        checks += 4;
        if (wr !== 1'b0) begin errors++; $display("FAIL mid_wr got %b exp 0", wr); end
        if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %b exp 1", empty); end
        if (usb_data_oe !== 1'b0) begin errors++; $display("FAIL mid_oe got %b exp 0", usb_data_oe); end
        if (state !== 3'd0) begin errors++; $display("FAIL mid_state got %0d exp 0", state); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 8'd0, 1'b0);
            if (wr === 1'b1)
                nwr++;
        end
        checks += 2;
        if (nwr != 0) begin errors++; $display("FAIL mid_post_wr got %0d exp 0", nwr); end
        if (empty !== 1'b1) begin errors++; $display("FAIL mid_post_empty got %b exp 1", empty); end
    endtask

    task automatic test_stream();
        logic [7:0] sent[$];
        int npushed = 0;
        int cyc = 0;
        bit p, t;
        logic [7:0] d;
        rx.delete();
        while ((npushed < 40 || rx.size() < 40) && cyc < 6000) begin
            p = npushed < 40 && q.size() < DEPTH && $urandom_range(0, 2) == 0;
            d = 8'($urandom);
            t = $urandom_range(0, 4) == 0;
            if (p) begin
                sent.push_back(d);
                npushed++;
            end
            tick(p, d, t);
            cyc++;
            checks += 4;
            if (count !== 5'(q.size())) begin errors++; $display("FAIL stream_count cyc %0d got %0d exp %0d", cyc, count, q.size()); end
            if (full !== (q.size() == DEPTH)) begin errors++; $display("FAIL stream_full cyc %0d got %b", cyc, full); end
            if (empty !== (q.size() == 0)) begin errors++; $display("FAIL stream_empty cyc %0d got %b", cyc, empty); end
            if (wr !== exp_wr()) begin errors++; $display("FAIL stream_wr cyc %0d got %b exp %b", cyc, wr, exp_wr()); end
        end
        checks += 2;
        if (cyc >= 6000) begin errors++; $display("FAIL stream_timeout got %0d bytes exp 40", rx.size()); end
        if (overflow !== m_ovf) begin errors++; $display("FAIL stream_ovf got %b exp %b", overflow, m_ovf); end
        for (int i = 0; i < sent.size() && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== sent[i]) begin errors++; $display("FAIL stream_rx[%0d] got %h exp %h", i, rx[i], sent[i]); end
        end
    endtask

    initial begin
        reset   = 1'b1;
        push    = 1'b0;
        in_data = 8'd0;
        txe     = 1'b1;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_txe_hold();
        test_overflow();
        test_reset_mid();
        test_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
